bus_slave_memory: RTL and testbench
===================================

// Module: bus_slave_memory
// PURPOSE
//  Responder end of the unidirectional master/arbiter bus: decodes the master's Address/Control, stores write data and returns read data from a
//  word-wide internal memory. Drives Ready for wait-state insertion and checks burst sequencing. One instance per chip-select slot behind the
//  arbiter/mux; serves as the bench target for the master FSM.
// PARAMETERS
//  CHIP_ID      2'b00  slot matched against Address[31:30]
//  ADDR_WIDTH   10     word index width, Address[9:0]
//  MEM_DEPTH    1024   words of storage (2**ADDR_WIDTH)
//  WAIT_STATES  0      Ready-low cycles inserted before accepting each STATUS_START beat (0..15)
// PORTS
//  clk       in   1   bus clock, rising edge
//  reset     in   1   asynchronous, active-high
//  Control   in   9   [8:7] status (00 START, 01 CONT, 10 IDLE, 11 BUSY), [6:3] burst len code, [2:1] size (B,HW,W,DW), [0] WE(1)/RE(0)
//  Address   in   32  [31:30] chip select, [9:0] word index
//  WData     in   32  write data, valid in data phase (cycle after address phase)
//  RData     out  32  read data, valid in data phase
//  Ready     out  1   1 = current address phase accepted / data phase complete
//  BurstErr  out  1   one-cycle pulse on burst protocol violation
//  DbgAddr   in   10  backdoor read index (verification only)
//  DbgData   out  32  combinational mem[DbgAddr]
// BEHAVIOUR
//  Reset: Ready=1, RData=0, BurstErr=0, FSM=S_IDLE, beat counter=0, no pending data phase. Memory contents are not cleared.
//  Selected = (Address[31:30]==CHIP_ID). Unselected or IDLE/BUSY status: no transfer accepted, Ready=1.
//  Accept edge: Ready=1 and selected and status START/CONT. At that edge, capture word index, WE and size into data-phase regs (dp_*).
//   Reads also load RData. Read lanes: B -> {24'b0,mem[7:0]}, HW -> {16'b0,mem[15:0]}, W/DW -> full word.
//  Data phase (cycle after accept): if dp_we, the next rising edge with Ready=1 writes WData into mem[dp_addr].
//   Write lanes: B [7:0], HW [15:0], W/DW [31:0]; untouched lanes keep their old value.
//  Forwarding: if a read is accepted on the same edge a data-phase write commits to the same word, RData returns the merged new value.
//  FSM:
//   S_IDLE   -> S_WAIT on selected START with WAIT_STATES>0. Ready drops the cycle after START is seen; wait counter loads WAIT_STATES-1.
//            -> S_ACTIVE on selected START with WAIT_STATES==0. Beat accepted immediately.
//   S_WAIT   Ready=0; counter decrements. At 0, Ready=1 and the held START beat is accepted -> S_ACTIVE.
//            Master holds Address/Control and WData while Ready=0.
//   S_ACTIVE CONT: accept the beat. START: new burst (via S_WAIT if WAIT_STATES>0). BUSY: hold without accepting.
//            IDLE or unselected: -> S_IDLE once the last data phase completes.
//  Burst length on START = 2**Control[6:3] beats, doubled when size==DW. Beat counter loads length-1 and decrements per accepted CONT.
//  BurstErr pulses (registered, 1 cycle) when:
//   - CONT arrives with counter==0 or in S_IDLE; the beat is still performed;
//   - START arrives with counter!=0; the new burst restarts the count.
//  Burst codes >4'd8 are not supported; counter width 10 bits, saturating.
//  Back-to-back write then read: read data is the post-write value (forwarding).
//  Reset mid-burst: pending data phase is discarded (no write); FSM, counters and outputs return to reset values immediately.
// STRUCTURE
//  Shared package bus_defs_pkg: STATUS_* codes, SIZE_* codes, WE/RE, the Control field-slice localparams, and the burst-length function.
//  All of these are also used by the master.
//  Sub-module slave_lane_mem: synchronous byte-lane write and asynchronous read array with a debug read port.
//  Top level holds the FSM, wait counter, burst checker, data-phase regs and forwarding.
// TESTING
//  1. Single W write 0x0000_0005 data 0xDEADBEEF, then W read of 0x5 -> RData=0xDEADBEEF in the read data phase, BurstErr=0.
//  2. WAIT_STATES=3, START read -> Ready low exactly 3 cycles, then high. Address stays held; RData correct on the accepting data phase.
//  3. Burst code 2 (4 beats), W writes to 0x10..0x13, with BUSY inserted after beat 2.
//     -> no beat accepted during BUSY; all 4 words written once; BurstErr=0.
//  4. Word 0x20=0x11223344; B write 0xAA -> word 0x112233AA. HW read -> RData=0x000033AA.
//  5. Write 0x30 immediately followed by read 0x30 -> forwarded new value returned. CONT with no START -> BurstErr pulses 1 cycle.
//  6. Assert reset during the write data phase -> Ready=1 and RData=0 asynchronously; target word unchanged per DbgData.
//     Chip select !=CHIP_ID -> no memory change.

Source files
------------

// File: rtl/bus_defs_pkg.sv
// Shared bus definitions used by the master and the slave.
//  - STATUS_* / SIZE_* / XFER_* codes carried in Control
//  - Control and Address field-slice positions
//  - burst length helper plus byte-lane helpers
package bus_defs_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CTRL_W     = 9;
  localparam int unsigned BEAT_CNT_W = 10;

  localparam int unsigned CTRL_STATUS_HI = 8;
  localparam int unsigned CTRL_STATUS_LO = 7;
  localparam int unsigned CTRL_BURST_HI  = 6;
  localparam int unsigned CTRL_BURST_LO  = 3;
  localparam int unsigned CTRL_SIZE_HI   = 2;
  localparam int unsigned CTRL_SIZE_LO   = 1;
  localparam int unsigned CTRL_WE_BIT    = 0;

  localparam int unsigned ADDR_CS_HI = 31;
  localparam int unsigned ADDR_CS_LO = 30;

  localparam logic [1:0] STATUS_START = 2'b00;
  localparam logic [1:0] STATUS_CONT  = 2'b01;
  localparam logic [1:0] STATUS_IDLE  = 2'b10;
  localparam logic [1:0] STATUS_BUSY  = 2'b11;

  localparam logic [1:0] SIZE_B  = 2'b00;
  localparam logic [1:0] SIZE_HW = 2'b01;
  localparam logic [1:0] SIZE_W  = 2'b10;
  localparam logic [1:0] SIZE_DW = 2'b11;

  localparam logic XFER_WE = 1'b1;
  localparam logic XFER_RE = 1'b0;

  // Beats in the burst minus one; DW doubles the count, result saturates.
  function automatic logic [BEAT_CNT_W-1:0] burst_len_m1(input logic [3:0] code,
                                                         input logic [1:0] size);
    logic [16:0] len;
    len = 17'd1 << code;
    if (size == SIZE_DW) len = len << 1;
    len = len - 17'd1;
    if (len > 17'(2**BEAT_CNT_W - 1)) return '1;
    return BEAT_CNT_W'(len);
  endfunction

  // Byte lanes touched by a transfer of the given size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] mask;
    mask = 4'b1111;
    case (size)
      SIZE_B:          mask = 4'b0001;
      SIZE_HW:         mask = 4'b0011;
      SIZE_W, SIZE_DW: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Read data with the unused upper lanes zeroed.
  function automatic logic [DATA_W-1:0] read_lanes(input logic [DATA_W-1:0] word,
                                                   input logic [1:0]        size);
    logic [DATA_W-1:0] res;
    res = word;
    case (size)
      SIZE_B:  res = {24'd0, word[7:0]};
      SIZE_HW: res = {16'd0, word[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/slave_lane_mem.sv
// Word-wide storage with per-byte write enables.
//  clk          write clock
//  we_i/be_i    write strobe and byte-lane enables
//  waddr_i      write word index, wdata_i write data
//  raddr_i      asynchronous read index -> rdata_c_o
//  dbg_addr_i   backdoor read index     -> dbg_data_c_o
module slave_lane_mem
  import bus_defs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_W-1:0]     rdata_c_o,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]     dbg_data_c_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_c_o    = mem_q[raddr_i];
  assign dbg_data_c_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/bus_slave_memory.sv
// Bus responder: decodes Address/Control for one chip-select slot, stores
// write data, returns read data, inserts wait states and checks bursts.
//  clk, reset   bus clock, asynchronous active-high reset
//  Control      {status[1:0], burst code[3:0], size[1:0], we}
//  Address      [31:30] chip select, [ADDR_WIDTH-1:0] word index
//  WData/RData  write data in / read data out, both in the data phase
//  Ready        address phase accepted / data phase complete
//  BurstErr     one-cycle pulse on burst sequencing violation
//  DbgAddr/Data combinational backdoor read of the array
module bus_slave_memory
  import bus_defs_pkg::*;
#(
  parameter logic [1:0]  CHIP_ID     = 2'b00,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_W-1:0]     Control,
  input  logic [31:0]           Address,
  input  logic [DATA_W-1:0]     WData,
  output logic [DATA_W-1:0]     RData,
  output logic                  Ready,
  output logic                  BurstErr,
  input  logic [ADDR_WIDTH-1:0] DbgAddr,
  output logic [DATA_W-1:0]     DbgData
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  // Address/Control decode
  logic [1:0]            status_c;
  logic [3:0]            burst_c;
  logic [1:0]            size_c;
  logic                  we_c;
  logic                  sel_c;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic                  unused_addr_c;

  assign status_c      = Control[CTRL_STATUS_HI:CTRL_STATUS_LO];
  assign burst_c       = Control[CTRL_BURST_HI:CTRL_BURST_LO];
  assign size_c        = Control[CTRL_SIZE_HI:CTRL_SIZE_LO];
  assign we_c          = Control[CTRL_WE_BIT];
  assign sel_c         = (Address[ADDR_CS_HI:ADDR_CS_LO] == CHIP_ID);
  assign idx_c         = Address[ADDR_WIDTH-1:0];
  assign unused_addr_c = ^Address[ADDR_CS_LO-1:ADDR_WIDTH];

  logic [1:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [BEAT_CNT_W-1:0] bcnt_q, bcnt_d;
  logic                  err_q, err_c;
  logic                  accept_c;

  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_we_q, dp_we_d;
  logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d;
  logic [1:0]            dp_size_q, dp_size_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  commit_c;
  logic [3:0]            be_c;
  logic [DATA_W-1:0]     mem_rdata_c;
  logic [DATA_W-1:0]     fwd_word_c;

  // Control FSM, wait counter and burst checker
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    err_c    = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      S_IDLE, S_ACTIVE: begin
        ready_d = 1'b1;
        if (!sel_c || status_c == STATUS_IDLE) begin
          state_d = S_IDLE;
        end else if (status_c == STATUS_START) begin
          // Checked and loaded when START is first seen, before any wait.
          if (bcnt_q != '0) err_c = 1'b1;
          bcnt_d = burst_len_m1(burst_c, size_c);
          if (HAS_WAIT) begin
            state_d = S_WAIT;
            ready_d = 1'b0;
            wcnt_d  = WAIT_LOAD;
          end else begin
            accept_c = 1'b1;
            state_d  = S_ACTIVE;
          end
        end else if (status_c == STATUS_CONT) begin
          accept_c = 1'b1;
          state_d  = S_ACTIVE;
          if (state_q == S_IDLE || bcnt_q == '0) err_c = 1'b1;
          if (bcnt_q != '0) bcnt_d = bcnt_q - BEAT_CNT_W'(1);
        end else if (status_c == STATUS_BUSY) begin
          state_d = state_q;
        end
      end
      S_WAIT: begin
        if (!ready_q) begin
          if (wcnt_q == 4'd0) ready_d = 1'b1;
          else                wcnt_d  = wcnt_q - 4'd1;
        end else if (sel_c && status_c == STATUS_START) begin
          // Wait done: the held START beat is taken now.
          accept_c = 1'b1;
          state_d  = S_ACTIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // A pending write completes on the next edge with Ready high.
  assign commit_c = ready_q & dp_valid_q & (dp_we_q == XFER_WE);
  assign be_c     = lane_mask(dp_size_q);

  // Merge a same-edge committing write into the read word.
  always_comb begin
    fwd_word_c = mem_rdata_c;
    if (commit_c && dp_addr_q == idx_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) fwd_word_c[8*b +: 8] = WData[8*b +: 8];
      end
    end
  end

  // Data-phase capture and read data load
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_we_d    = dp_we_q;
    dp_addr_d  = dp_addr_q;
    dp_size_d  = dp_size_q;
    rdata_d    = rdata_q;
    if (ready_q) begin
      dp_valid_d = accept_c;
      dp_we_d    = we_c;
      dp_addr_d  = idx_c;
      dp_size_d  = size_c;
    end
    if (accept_c && we_c == XFER_RE) rdata_d = read_lanes(fwd_word_c, size_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      wcnt_q     <= 4'd0;
      bcnt_q     <= '0;
      err_q      <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_we_q    <= 1'b0;
      dp_addr_q  <= '0;
      dp_size_q  <= SIZE_B;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      err_q      <= err_c;
      dp_valid_q <= dp_valid_d;
      dp_we_q    <= dp_we_d;
      dp_addr_q  <= dp_addr_d;
      dp_size_q  <= dp_size_d;
      rdata_q    <= rdata_d;
    end
  end

  slave_lane_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_mem (
    .clk          (clk),
    .we_i         (commit_c),
    .be_i         (be_c),
    .waddr_i      (dp_addr_q),
    .wdata_i      (WData),
    .raddr_i      (idx_c),
    .rdata_c_o    (mem_rdata_c),
    .dbg_addr_i   (DbgAddr),
    .dbg_data_c_o (DbgData)
  );

  assign RData    = rdata_q;
  assign Ready    = ready_q;
  assign BurstErr = err_q;

endmodule

// File: tb/tb_bus_slave_memory.sv
// Bench for bus_slave_memory: two slots on one bus, slot 0 with no wait
// states and slot 1 with three, checked against a behavioural bus model.
module tb_bus_slave_memory;
  import bus_defs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  Control;
  logic [31:0] Address;
  logic [31:0] WData;
  logic [31:0] rdata0, rdata1, dbg0, dbg1;
  logic        ready0, ready1, err0, err1;
  logic [9:0]  DbgAddr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_mem [2][1024];
  logic [9:0]  m_bcnt [2];
  bit          m_inb [2];
  bit          pend_v;
  int          pend_d;
  logic [9:0]  pend_idx;
  logic [1:0]  pend_sz;
  logic [31:0] pend_wd;

  always #5 clk = ~clk;

  bus_slave_memory #(.CHIP_ID(2'b00), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .Control(Control), .Address(Address), .WData(WData),
    .RData(rdata0), .Ready(ready0), .BurstErr(err0), .DbgAddr(DbgAddr), .DbgData(dbg0));

  bus_slave_memory #(.CHIP_ID(2'b01), .ADDR_WIDTH(10), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(reset), .Control(Control), .Address(Address), .WData(WData),
    .RData(rdata1), .Ready(ready1), .BurstErr(err1), .DbgAddr(DbgAddr), .DbgData(dbg1));

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [1:0] sz);
    if (sz == 2'd0) return {old[31:8], nw[7:0]};
    if (sz == 2'd1) return {old[31:16], nw[15:0]};
    return nw;
  endfunction

  function automatic logic [31:0] m_rlane(input logic [31:0] w, input logic [1:0] sz);
    if (sz == 2'd0) return w & 32'h0000_00FF;
    if (sz == 2'd1) return w & 32'h0000_FFFF;
    return w;
  endfunction

  function automatic logic [9:0] m_lenm1(input logic [3:0] code, input logic [1:0] sz);
    int len;
    len = 2 ** code;
    if (sz == 2'd3) len = len * 2;
    len = len - 1;
    if (len > 1023) len = 1023;
    return 10'(len);
  endfunction

  // One address phase: drive, wait for acceptance, update and check the model.
  task automatic beat(input logic [1:0] st, input logic [3:0] code, input logic [1:0] sz,
                      input logic we, input logic [1:0] cs, input logic [9:0] idx,
                      input logic [31:0] wd_next, input string tag);
    int d, low;
    bit sel, acc, exp_wait, done, committed, rdy, exp_err;
    logic [31:0] exp_rd, got_rd;
    logic got_err, oth_err;
    d   = (cs == 2'd1) ? 1 : 0;
    sel = (cs <= 2'd1);
    acc = sel && (st == STATUS_START || st == STATUS_CONT);
    Control = {st, code, sz, we};
    Address = {cs, 20'd0, idx};
    WData   = pend_v ? pend_wd : $urandom();
    exp_err = 1'b0;
    for (int k = 0; k < 2; k++) if (!(sel && k == d)) m_inb[k] = 1'b0;
    if (sel) begin
      if (st == STATUS_START) begin
        exp_err = (m_bcnt[d] != 10'd0);
        m_bcnt[d] = m_lenm1(code, sz);
        m_inb[d] = 1'b1;
      end else if (st == STATUS_CONT) begin
        exp_err = !m_inb[d] || (m_bcnt[d] == 10'd0);
        if (m_bcnt[d] != 10'd0) m_bcnt[d] = m_bcnt[d] - 10'd1;
        m_inb[d] = 1'b1;
      end else if (st == STATUS_IDLE) begin
        m_inb[d] = 1'b0;
      end
    end
    exp_wait = sel && (d == 1) && (st == STATUS_START);
    low = 0; done = 1'b0; committed = 1'b0;
    for (int g = 0; g < 32 && !done; g++) begin
      rdy = ready0 & ready1;
      @(posedge clk);
      if (rdy && !committed) begin
        if (pend_v) m_mem[pend_d][pend_idx] = m_merge(m_mem[pend_d][pend_idx], pend_wd, pend_sz);
        pend_v = 1'b0;
        committed = 1'b1;
      end
      if (rdy && (!exp_wait || low > 0)) done = 1'b1;
      else if (!rdy) low++;
      #1;
      if (g == 0) begin
        got_err = (d == 1) ? err1 : err0;
        oth_err = (d == 1) ? err0 : err1;
        n_tests++;
        if (got_err !== exp_err) begin
          n_fail++;
          $display("FAIL %s burst_err: got %b expected %b", tag, got_err, exp_err);
        end
        n_tests++;
        if (oth_err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s other_slot_err: got %b expected 0", tag, oth_err);
        end
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s accept_timeout: got no accept expected accept within 32 cycles", tag);
    end
    if (exp_wait) begin
      n_tests++;
      if (low != 3) begin
        n_fail++;
        $display("FAIL %s ready_low_cycles: got %0d expected 3", tag, low);
      end
    end
    if (acc && we) begin
      pend_v = 1'b1; pend_d = d; pend_idx = idx; pend_sz = sz; pend_wd = wd_next;
    end
    if (acc && !we) begin
      exp_rd = m_rlane(m_mem[d][idx], sz);
      got_rd = (d == 1) ? rdata1 : rdata0;
      n_tests++;
      if (got_rd !== exp_rd) begin
        n_fail++;
        $display("FAIL %s rdata: got %h expected %h", tag, got_rd, exp_rd);
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b%b expected 11", ready0, ready1);
    end
    n_tests++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0", rdata0, rdata1);
    end
    n_tests++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_bursterr: got %b%b expected 00", err0, err1);
    end
  endtask

  task automatic test_single_rw();
    beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd0, 10'h005, 32'hDEADBEEF, "single_wr");
    beat(STATUS_START, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h005, 32'h0, "single_rd");
    n_tests++;
    if (rdata0 !== 32'hDEADBEEF || err0 !== 1'b0) begin
      n_fail++; $display("FAIL single_rw: got %h err %b expected deadbeef err 0", rdata0, err0);
    end
    beat(STATUS_IDLE, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h0, 32'h0, "single_idle");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++)
      beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd0, 10'(i), $urandom(), "fill0");
    for (int i = 0; i < 8; i++)
      beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd1, 10'(i), $urandom(), "fill1");
    beat(STATUS_IDLE, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h0, 32'h0, "fill_idle");
    for (int i = 0; i < 8; i++) begin
      DbgAddr = 10'(i); #1;
      n_tests++;
      if (dbg1 !== m_mem[1][i]) begin
        n_fail++; $display("FAIL fill1_mem[%0d]: got %h expected %h", i, dbg1, m_mem[1][i]);
      end
    end
  endtask

  task automatic test_wait_states();
    beat(STATUS_START, 4'd0, SIZE_W, 1'b0, 2'd1, 10'h003, 32'h0, "wait_rd");
    beat(STATUS_START, 4'd0, SIZE_HW, 1'b0, 2'd1, 10'h006, 32'h0, "wait_rd_hw");
    beat(STATUS_IDLE, 4'd0, SIZE_W, 1'b0, 2'd1, 10'h0, 32'h0, "wait_idle");
  endtask

  task automatic test_burst_busy();
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = $urandom();
    beat(STATUS_START, 4'd2, SIZE_W, 1'b1, 2'd0, 10'h010, d[0], "burst_b0");
    beat(STATUS_CONT,  4'd2, SIZE_W, 1'b1, 2'd0, 10'h011, d[1], "burst_b1");
    beat(STATUS_BUSY,  4'd2, SIZE_W, 1'b1, 2'd0, 10'h014, 32'h0, "burst_busy");
    beat(STATUS_CONT,  4'd2, SIZE_W, 1'b1, 2'd0, 10'h012, d[2], "burst_b2");
    beat(STATUS_CONT,  4'd2, SIZE_W, 1'b1, 2'd0, 10'h013, d[3], "burst_b3");
    beat(STATUS_IDLE,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h0, 32'h0, "burst_idle");
    for (int i = 0; i < 8; i++) begin
      DbgAddr = 10'(16 + i); #1;
      n_tests++;
      if (i < 4 && dbg0 !== d[i]) begin
        n_fail++; $display("FAIL burst_mem[%0d]: got %h expected %h", 16 + i, dbg0, d[i]);
      end else if (i >= 4 && dbg0 !== m_mem[0][16 + i]) begin
        n_fail++; $display("FAIL burst_mem[%0d]: got %h expected %h", 16 + i, dbg0, m_mem[0][16 + i]);
      end
    end
  endtask

  task automatic test_lanes();
    beat(STATUS_START, 4'd0, SIZE_W,  1'b1, 2'd0, 10'h020, 32'h11223344, "lane_w");
    beat(STATUS_START, 4'd0, SIZE_B,  1'b1, 2'd0, 10'h020, 32'h000000AA, "lane_b");
    beat(STATUS_START, 4'd0, SIZE_HW, 1'b0, 2'd0, 10'h020, 32'h0, "lane_hw_rd");
    n_tests++;
    if (rdata0 !== 32'h000033AA) begin
      n_fail++; $display("FAIL lane_hw_value: got %h expected 000033aa", rdata0);
    end
    beat(STATUS_IDLE, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h0, 32'h0, "lane_idle");
    DbgAddr = 10'h020; #1;
    n_tests++;
    if (dbg0 !== 32'h112233AA) begin
      n_fail++; $display("FAIL lane_mem: got %h expected 112233aa", dbg0);
    end
  endtask

  task automatic test_fwd_err();
    logic [31:0] v;
    v = $urandom();
    beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd0, 10'h030, v, "fwd_wr");
    beat(STATUS_START, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h030, 32'h0, "fwd_rd");
    n_tests++;
    if (rdata0 !== v) begin
      n_fail++; $display("FAIL fwd_value: got %h expected %h", rdata0, v);
    end
    beat(STATUS_IDLE,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h0,   32'h0, "err_idle");
    beat(STATUS_CONT,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h031, 32'h0, "err_cont_no_start");
    beat(STATUS_IDLE,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h0,   32'h0, "err_pulse_end");
    beat(STATUS_START, 4'd1, SIZE_W, 1'b0, 2'd0, 10'h032, 32'h0, "err_start_a");
    beat(STATUS_START, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h033, 32'h0, "err_start_early");
    beat(STATUS_CONT,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h034, 32'h0, "err_cont_over");
    beat(STATUS_IDLE,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h0,   32'h0, "err_idle2");
  endtask

  task automatic test_random();
    int r;
    logic [1:0] st, cs;
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      cs = 2'd0;
      if (r <= 3)      st = STATUS_START;
      else if (r <= 6) st = STATUS_CONT;
      else if (r == 7) st = STATUS_BUSY;
      else if (r == 8) st = STATUS_IDLE;
      else begin st = STATUS_START; cs = 2'd2 + 2'($urandom_range(0, 1)); end
      beat(st, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           cs, 10'($urandom_range(0, 63)), $urandom(), "rand");
    end
    beat(STATUS_IDLE, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h0, 32'h0, "rand_idle");
    for (int i = 0; i < 64; i++) begin
      DbgAddr = 10'(i); #1;
      n_tests++;
      if (dbg0 !== m_mem[0][i]) begin
        n_fail++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, dbg0, m_mem[0][i]);
      end
    end
  endtask

  task automatic test_chip_select();
    logic [31:0] o0, o1;
    o0 = m_mem[0][5]; o1 = m_mem[1][5];
    beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd3, 10'h005, 32'hBAD0BAD0, "cs3_wr");
    beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd2, 10'h005, 32'h0BADF00D, "cs2_wr");
    beat(STATUS_IDLE,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h0, 32'h0, "cs_idle");
    DbgAddr = 10'h005; #1;
    n_tests++;
    if (dbg0 !== o0 || dbg1 !== o1) begin
      n_fail++; $display("FAIL cs_nochange: got %h/%h expected %h/%h", dbg0, dbg1, o0, o1);
    end
  endtask

  task automatic test_reset_mid();
    beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd0, 10'h040, 32'hCAFEF00D, "rst_pre_wr");
    beat(STATUS_START, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h040, 32'h0, "rst_pre_rd");
    beat(STATUS_START, 4'd0, SIZE_W, 1'b1, 2'd0, 10'h040, 32'h12345678, "rst_wr");
    WData   = pend_wd;
    Control = {STATUS_IDLE, 4'd0, SIZE_W, 1'b0};
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (ready0 !== 1'b1 || rdata0 !== 32'h0 || err0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got ready %b rdata %h err %b expected 1 0 0",
                         ready0, rdata0, err0);
    end
    pend_v = 1'b0;
    m_bcnt[0] = 10'd0; m_bcnt[1] = 10'd0; m_inb[0] = 1'b0; m_inb[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    DbgAddr = 10'h040; #1;
    n_tests++;
    if (dbg0 !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rst_no_write: got %h expected cafef00d", dbg0);
    end
    beat(STATUS_START, 4'd0, SIZE_W, 1'b0, 2'd0, 10'h040, 32'h0, "rst_post_rd");
    beat(STATUS_IDLE,  4'd0, SIZE_W, 1'b0, 2'd0, 10'h0, 32'h0, "rst_post_idle");
  endtask

  initial begin
    reset   = 1'b1;
    Control = {STATUS_IDLE, 4'd0, SIZE_W, 1'b0};
    Address = 32'h0;
    WData   = 32'h0;
    DbgAddr = 10'h0;
    pend_v  = 1'b0;
    pend_d  = 0;
    m_bcnt[0] = 10'd0; m_bcnt[1] = 10'd0; m_inb[0] = 1'b0; m_inb[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    test_single_rw();
    test_fill();
    test_wait_states();
    test_burst_busy();
    test_lanes();
    test_fwd_err();
    test_random();
    test_chip_select();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of run");
    $fatal(1);
  end

endmodule
